fifo_pkt_drain: RTL and testbench

//  Read-side consumer of a per-priority packet fifo. Issues read, takes back the sop/eop/vld/data word stream,

---
 rtl/fifo_pkt_drain.sv | 167 ++++++++++++++++
 tb/tb_fifo_pkt_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_drain.sv
// Read-side drain of a priority packet fifo: frames the sop/eop word stream into SRAM
// at a wrapping write pointer and emits one (start, length) descriptor per good packet.
module fifo_pkt_drain #(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned MAX_PKT_WORDS = 64,
  parameter int unsigned LEN_WIDTH     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  read,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  desc_vld,
  input  logic                  desc_ready,
  output logic [ADDR_WIDTH-1:0] desc_addr,
  output logic [LEN_WIDTH-1:0]  desc_len,
  output logic                  err_vld,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  localparam logic [1:0]            ERR_ORPHAN   = 2'd1;
  localparam logic [1:0]            ERR_NO_EOP   = 2'd2;
  localparam logic [1:0]            ERR_OVERSIZE = 2'd3;
  localparam logic [LEN_WIDTH-1:0]  MAX_CNT      = LEN_WIDTH'(MAX_PKT_WORDS);
  localparam logic [LEN_WIDTH-1:0]  ONE_LEN      = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR     = ADDR_WIDTH'(1);

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   pkt_start, pkt_start_d;
  logic [LEN_WIDTH-1:0]    word_cnt, word_cnt_d;
  logic                    mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_d;
  logic                    desc_vld_d;
  logic [ADDR_WIDTH-1:0]   desc_addr_d;
  logic [LEN_WIDTH-1:0]    desc_len_d;
  logic                    err_vld_d;
  logic [1:0]              err_code_d;
  logic                    start_pkt;
  logic [ADDR_WIDTH-1:0]   start_addr;

  // The bubble after each returned eop keeps at most one packet in flight.
  assign read = en & ~rst & ~desc_vld & ~(in_vld & in_eop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      pkt_start <= '0;
      word_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      desc_vld  <= 1'b0;
      desc_addr <= '0;
      desc_len  <= '0;
      err_vld   <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_d;
      wr_ptr    <= wr_ptr_d;
      pkt_start <= pkt_start_d;
      word_cnt  <= word_cnt_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      desc_vld  <= desc_vld_d;
      desc_addr <= desc_addr_d;
      desc_len  <= desc_len_d;
      err_vld   <= err_vld_d;
      err_code  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    pkt_start_d = pkt_start;
    word_cnt_d  = word_cnt;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    desc_vld_d  = desc_vld & ~desc_ready;
    desc_addr_d = desc_addr;
    desc_len_d  = desc_len;
    err_vld_d   = 1'b0;
    err_code_d  = 2'd0;
    start_pkt   = 1'b0;
    start_addr  = wr_ptr;

    if (in_vld) begin
      case (state)
        IDLE: begin
          if (in_sop) begin
            start_pkt = 1'b1;
          end else begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_ORPHAN;
          end
        end
        BODY: begin
          if (in_sop) begin
            // Abandon the partial packet and reuse its space for the new one.
            err_vld_d  = 1'b1;
            err_code_d = ERR_NO_EOP;
            start_pkt  = 1'b1;
            start_addr = pkt_start;
          end else if (word_cnt == MAX_CNT) begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_OVERSIZE;
            wr_ptr_d   = pkt_start;
            state_d    = in_eop ? IDLE : DROP;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr;
            mem_wdata_d = in_data;
            wr_ptr_d    = wr_ptr + ONE_ADDR;
            word_cnt_d  = word_cnt + ONE_LEN;
            if (in_eop) begin
              desc_vld_d  = 1'b1;
              desc_addr_d = pkt_start;
              desc_len_d  = word_cnt + ONE_LEN;
              state_d     = IDLE;
            end
          end
        end
        DROP: begin
          if (in_sop) begin
            start_pkt = 1'b1;
          end else if (in_eop) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // First word of a packet, shared by IDLE, DROP and the BODY restart.
    if (start_pkt) begin
      pkt_start_d = start_addr;
      word_cnt_d  = ONE_LEN;
      mem_we_d    = 1'b1;
      mem_addr_d  = start_addr;
      mem_wdata_d = in_data;
      wr_ptr_d    = start_addr + ONE_ADDR;
      if (in_eop) begin
        desc_vld_d  = 1'b1;
        desc_addr_d = start_addr;
        desc_len_d  = ONE_LEN;
        state_d     = IDLE;
      end else begin
        state_d = BODY;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Directed bench for fifo_pkt_drain: a behavioural fifo answers read strobes one
// cycle later, and writes, errors and descriptors are logged against hand-computed values.
module tb_fifo_pkt_drain;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned LW = 7;

  logic          clk;
  logic          rst;
  logic          en;
  logic          read;
  logic          in_sop;
  logic          in_eop;
  logic          in_vld;
  logic [DW-1:0] in_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          desc_vld;
  logic          desc_ready;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic          err_vld;
  logic [1:0]    err_code;

  int errors = 0;
  int checks = 0;

  logic [33:0] fq[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] da[$];
  logic [31:0] dl[$];
  logic [31:0] ec[$];
  logic [31:0] erd[$];

  fifo_pkt_drain #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKT_WORDS(4), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .read(read),
    .in_sop(in_sop), .in_eop(in_eop), .in_vld(in_vld), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .desc_vld(desc_vld), .desc_ready(desc_ready), .desc_addr(desc_addr), .desc_len(desc_len),
    .err_vld(err_vld), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return 32'hdead_beef;
  endfunction

  task automatic push(input logic sop, input logic eop, input logic [31:0] data);
    fq.push_back({sop, eop, data});
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); da.delete(); dl.delete(); ec.delete(); erd.delete();
  endtask

  // One clock: fifo answers the read sampled before the edge, outputs are logged after it.
  task automatic step();
    logic        rd;
    logic [33:0] w;
    #1;
    rd = read;
    if (desc_vld && desc_ready) begin
      da.push_back(32'(desc_addr));
      dl.push_back(32'(desc_len));
    end
    @(posedge clk);
    #1;
    if (mem_we) begin
      wa.push_back(32'(mem_addr));
      wd.push_back(32'(mem_wdata));
    end
    if (err_vld) ec.push_back(32'(err_code));
    if (rd && fq.size() > 0) begin
      w = fq.pop_front();
      in_sop  = w[33];
      in_eop  = w[32];
      in_data = w[31:0];
      in_vld  = 1'b1;
    end else begin
      in_sop = 1'b0;
      in_eop = 1'b0;
      in_vld = 1'b0;
    end
    #1;
    if (in_vld && in_eop) erd.push_back(32'(read));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fq.size() != 0 || in_vld || desc_vld || mem_we) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(fq.size()), 32'd0);
    step();
    step();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_read"},      32'(read),      32'd0);
    chk({pfx, "_mem_we"},    32'(mem_we),    32'd0);
    chk({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({pfx, "_desc_vld"},  32'(desc_vld),  32'd0);
    chk({pfx, "_desc_addr"}, 32'(desc_addr), 32'd0);
    chk({pfx, "_desc_len"},  32'(desc_len),  32'd0);
    chk({pfx, "_err_vld"},   32'(err_vld),   32'd0);
    chk({pfx, "_err_code"},  32'(err_code),  32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; desc_ready = 1'b1;
    in_sop = 1'b0; in_eop = 1'b0; in_vld = 1'b0; in_data = '0;

    // Reset values
    step(); step();
    chk_reset_outputs("rst0");
    rst = 1'b0;
    en  = 1'b1;
    step();

    // 1: three-word packet from address 0
    clear_logs();
    push(1'b1, 1'b0, 32'h101); push(1'b0, 1'b0, 32'h102); push(1'b0, 1'b1, 32'h103);
    drain(50);
    chk("t1_nwr",   32'(wa.size()), 32'd3);
    chk("t1_wa0",   qget(wa, 0), 32'd0);
    chk("t1_wa1",   qget(wa, 1), 32'd1);
    chk("t1_wa2",   qget(wa, 2), 32'd2);
    chk("t1_wd1",   qget(wd, 1), 32'h102);
    chk("t1_ndesc", 32'(da.size()), 32'd1);
    chk("t1_daddr", qget(da, 0), 32'd0);
    chk("t1_dlen",  qget(dl, 0), 32'd3);
    chk("t1_eoprd", qget(erd, 0), 32'd0);
    chk("t1_nerr",  32'(ec.size()), 32'd0);

    // 2: single-word packet, descriptor back-pressured for 5 cycles
    clear_logs();
    desc_ready = 1'b0;
    push(1'b1, 1'b1, 32'h201);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_vld", 32'(desc_vld), 32'd1);
      chk("t2_hold_rd",  32'(read),     32'd0);
      step();
    end
    chk("t2_daddr", 32'(desc_addr), 32'd3);
    chk("t2_dlen",  32'(desc_len),  32'd1);
    desc_ready = 1'b1;
    chk("t2_hs_rd", 32'(read), 32'd0);
    step();
    chk("t2_post_vld", 32'(desc_vld), 32'd0);
    chk("t2_post_rd",  32'(read),     32'd1);
    chk("t2_wa0", qget(wa, 0), 32'd3);
    chk("t2_wd0", qget(wd, 0), 32'h201);

    // 3: orphan word in IDLE
    clear_logs();
    push(1'b0, 1'b0, 32'h301);
    step(); step();
    chk("t3_errv", 32'(err_vld),  32'd1);
    chk("t3_errc", 32'(err_code), 32'd1);
    step();
    chk("t3_errv_pulse", 32'(err_vld), 32'd0);
    step(); step();
    chk("t3_nwr",  32'(wa.size()), 32'd0);
    chk("t3_nerr", 32'(ec.size()), 32'd1);

    // 4: sop, word, then a new sop restarts at the old start address
    clear_logs();
    push(1'b1, 1'b0, 32'h401); push(1'b0, 1'b0, 32'h402);
    push(1'b1, 1'b0, 32'h403); push(1'b0, 1'b1, 32'h404);
    drain(50);
    chk("t4_nerr",  32'(ec.size()), 32'd1);
    chk("t4_errc",  qget(ec, 0), 32'd2);
    chk("t4_wa2",   qget(wa, 2), 32'd4);
    chk("t4_wd2",   qget(wd, 2), 32'h403);
    chk("t4_wa3",   qget(wa, 3), 32'd5);
    chk("t4_daddr", qget(da, 0), 32'd4);
    chk("t4_dlen",  qget(dl, 0), 32'd2);

    // 5: six-word packet with a 4-word limit, then a packet at the original start
    clear_logs();
    for (int i = 1; i <= 6; i++) push(i == 1, i == 6, 32'h500 + 32'(i));
    push(1'b1, 1'b1, 32'h507);
    drain(60);
    chk("t5_nwr",   32'(wa.size()), 32'd5);
    chk("t5_wa3",   qget(wa, 3), 32'd9);
    chk("t5_wa4",   qget(wa, 4), 32'd6);
    chk("t5_wd4",   qget(wd, 4), 32'h507);
    chk("t5_nerr",  32'(ec.size()), 32'd1);
    chk("t5_errc",  qget(ec, 0), 32'd3);
    chk("t5_ndesc", 32'(da.size()), 32'd1);
    chk("t5_daddr", qget(da, 0), 32'd6);
    chk("t5_dlen",  qget(dl, 0), 32'd1);

    // Advance the write pointer from 7 to 4094 with filler packets
    clear_logs();
    for (int k = 0; k < 1021; k++)
      for (int j = 0; j < 4; j++) push(j == 0, j == 3, 32'hf000_0000 | 32'(k));
    push(1'b1, 1'b0, 32'he1); push(1'b0, 1'b0, 32'he2); push(1'b0, 1'b1, 32'he3);
    drain(20000);
    chk("fill_ndesc", 32'(da.size()), 32'd1022);
    chk("fill_daddr", qget(da, 1021), 32'd4091);
    chk("fill_dlen",  qget(dl, 1021), 32'd3);
    chk("fill_nerr",  32'(ec.size()), 32'd0);

    // 6: packet wrapping the address space
    clear_logs();
    for (int i = 1; i <= 4; i++) push(i == 1, i == 4, 32'h600 + 32'(i));
    drain(50);
    chk("t6_wa0",   qget(wa, 0), 32'd4094);
    chk("t6_wa1",   qget(wa, 1), 32'd4095);
    chk("t6_wa2",   qget(wa, 2), 32'd0);
    chk("t6_wa3",   qget(wa, 3), 32'd1);
    chk("t6_wd3",   qget(wd, 3), 32'h604);
    chk("t6_daddr", qget(da, 0), 32'd4094);
    chk("t6_dlen",  qget(dl, 0), 32'd4);

    // Reset in the middle of a packet
    clear_logs();
    push(1'b1, 1'b0, 32'h701); push(1'b0, 1'b0, 32'h702);
    push(1'b0, 1'b0, 32'h703); push(1'b0, 1'b1, 32'h704);
    step(); step(); step();
    rst = 1'b1;
    fq.delete();
    step();
    chk_reset_outputs("rst_mid");
    rst = 1'b0;
    clear_logs();
    push(1'b1, 1'b1, 32'h801);
    drain(50);
    chk("rst_ndesc", 32'(da.size()), 32'd1);
    chk("rst_daddr", qget(da, 0), 32'd0);
    chk("rst_dlen",  qget(dl, 0), 32'd1);
    chk("rst_wa0",   qget(wa, 0), 32'd0);
    chk("rst_nerr",  32'(ec.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
